// File: rtl/alu_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_hazard_ctrl_pkg
//
// Purpose:
//   Shared types and constants for the ALU hazard/forwarding controller.
//
// Contents:
//   REG_ADDR_W   register index width (8 architectural registers)
//   CNT_W        width of the optional performance counters
//   FWD_*        operand mux select encodings
//   slot_t       EX slot contents {valid, wr, load, dst}
//   prod_t       MEM slot contents {valid, wr, dst}
//   slot_match   "this slot produces the register this operand reads"
//
// Optional feature macro: HAZARD_PERF_CNT_EN (uses CNT_W).
// ---------------------------------------------------------------------------
package alu_hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int CNT_W      = 16;

  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_EXMEM   = 2'd1;
  localparam logic [1:0] FWD_MEMWB   = 2'd2;

  typedef struct packed {
    logic                  valid;
    logic                  wr;
    logic                  load;
    logic [REG_ADDR_W-1:0] dst;
  } slot_t;

  // Once an instruction has left EX its result (load data included) comes
  // back through result_buf2, so the load flag is no longer carried.
  typedef struct packed {
    logic                  valid;
    logic                  wr;
    logic [REG_ADDR_W-1:0] dst;
  } prod_t;

  // Register 0 is an ordinary register here, so no zero-index exclusion.
  function automatic logic slot_match(input logic                  valid,
                                      input logic                  wr,
                                      input logic [REG_ADDR_W-1:0] dst,
                                      input logic [REG_ADDR_W-1:0] src,
                                      input logic                  use_src);
    return use_src && valid && wr && (dst == src);
  endfunction

endpackage

// File: rtl/alu_hazard_ctrl_fwd_select.sv
// ---------------------------------------------------------------------------
// alu_fwd_select
//
// Purpose:
//   Purely combinational forwarding decision for one ALU operand. Compares
//   the operand's source register against the producers in the EX and MEM
//   slots and picks the operand mux select the operand will need once it
//   sits in EX.
//
// Ports:
//   src       in   operand register index
//   use_src   in   operand is actually read by the instruction
//   ex_slot   in   current EX slot (becomes MEM when this operand issues)
//   mem_slot  in   current MEM slot (becomes WB when this operand issues)
//   sel       out  FWD_REGFILE / FWD_EXMEM / FWD_MEMWB
//   load_hit  out  operand needs a load that is still in EX (load-use)
// ---------------------------------------------------------------------------
module alu_fwd_select
  import alu_hazard_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  use_src,
  input  slot_t                 ex_slot,
  input  prod_t                 mem_slot,
  output logic [1:0]            sel,
  output logic                  load_hit
);

  logic ex_hit;
  logic mem_hit;

  // The EX producer is younger than the MEM producer, so it is checked
  // first and wins when both write the same register.
  always_comb begin
    ex_hit   = slot_match(ex_slot.valid, ex_slot.wr, ex_slot.dst, src, use_src);
    mem_hit  = slot_match(mem_slot.valid, mem_slot.wr, mem_slot.dst, src, use_src);
    load_hit = ex_hit && ex_slot.load;
    sel      = FWD_REGFILE;
    if (ex_hit) begin
      sel = FWD_EXMEM;
    end else if (mem_hit) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/alu_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// alu_hazard_ctrl
//
// Purpose:
//   Operand sourcing and issue control for the pipelined ALU stage. Tracks
//   the producers in flight, registers the operand forwarding selects as an
//   instruction issues into EX, and raises a one-cycle stall on load-use.
//
// Ports:
//   clk        in   pipeline clock
//   rst_n      in   asynchronous active-low reset
//   id_valid   in   decode holds a valid instruction
//   id_src1    in   operand-1 register index
//   id_src2    in   operand-2 register index
//   id_use1    in   instruction reads src1
//   id_use2    in   instruction reads src2
//   id_dst     in   destination register index
//   id_wr      in   instruction writes id_dst
//   id_load    in   instruction is a load
//   flush      in   squash decode and the EX slot
//   stall      out  combinational hold of fetch/decode
//   ex_valid   out  EX slot holds a real instruction
//   fwd_sel1   out  operand-1 mux select (registered)
//   fwd_sel2   out  operand-2 mux select (registered)
//   stall_cnt  out  saturating stall-cycle count (HAZARD_PERF_CNT_EN only)
//   fwd_cnt    out  saturating forwarded-issue count (HAZARD_PERF_CNT_EN only)
//
// Optional feature macro: HAZARD_PERF_CNT_EN.
// ---------------------------------------------------------------------------
module alu_hazard_ctrl
  import alu_hazard_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_use1,
  input  logic                  id_use2,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_wr,
  input  logic                  id_load,
  input  logic                  flush,
  output logic                  stall,
  output logic                  ex_valid,
  output logic [1:0]            fwd_sel1,
  output logic [1:0]            fwd_sel2
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      fwd_cnt
`endif
);

  // The WB slot is not held in flops: an instruction in WB is writing the
  // register file while the consumer reads it, so it never changes a select.
  slot_t      ex_slot;
  prod_t      mem_slot;

  logic [1:0] sel1_next;
  logic [1:0] sel2_next;
  logic       load_hit1;
  logic       load_hit2;
  logic       issue;

  alu_fwd_select u_fwd1 (
    .src      (id_src1),
    .use_src  (id_use1),
    .ex_slot  (ex_slot),
    .mem_slot (mem_slot),
    .sel      (sel1_next),
    .load_hit (load_hit1)
  );

  alu_fwd_select u_fwd2 (
    .src      (id_src2),
    .use_src  (id_use2),
    .ex_slot  (ex_slot),
    .mem_slot (mem_slot),
    .sel      (sel2_next),
    .load_hit (load_hit2)
  );

  // Flush takes priority over the load-use stall: the consumer is being
  // squashed anyway, so there is nothing to wait for.
  always_comb begin
    stall = id_valid && !flush && (load_hit1 || load_hit2);
    issue = id_valid && !stall && !flush;
  end

  // The slots advance every cycle. A stalled or flushed cycle issues a
  // bubble into EX, which also returns both selects to the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_slot  <= '0;
      mem_slot <= '0;
      fwd_sel1 <= FWD_REGFILE;
      fwd_sel2 <= FWD_REGFILE;
    end else begin
      mem_slot.valid <= ex_slot.valid;
      mem_slot.wr    <= ex_slot.wr;
      mem_slot.dst   <= ex_slot.dst;
      if (issue) begin
        ex_slot.valid <= 1'b1;
        ex_slot.wr    <= id_wr;
        ex_slot.load  <= id_load;
        ex_slot.dst   <= id_dst;
        fwd_sel1      <= sel1_next;
        fwd_sel2      <= sel2_next;
      end else begin
        ex_slot       <= '0;
        fwd_sel1      <= FWD_REGFILE;
        fwd_sel2      <= FWD_REGFILE;
      end
    end
  end

  assign ex_valid = ex_slot.valid;

`ifdef HAZARD_PERF_CNT_EN
  logic fwd_event;

  always_comb begin
    fwd_event = issue && ((sel1_next != FWD_REGFILE) || (sel2_next != FWD_REGFILE));
  end

  // Both counters stop at all-ones rather than wrapping so a long run never
  // reports a misleadingly small figure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (fwd_event && (fwd_cnt != {CNT_W{1'b1}})) begin
        fwd_cnt <= fwd_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_hazard_ctrl
//
// Directed bench for alu_hazard_ctrl. Each step drives one decode slot just
// after a rising edge, checks the combinational stall for that slot together
// with the registered outputs of whatever issued on the previous edge, then
// advances one clock. Counter checks are included when HAZARD_PERF_CNT_EN is
// defined.
// ---------------------------------------------------------------------------
module tb_alu_hazard_ctrl;
  import alu_hazard_ctrl_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_use1;
  logic                  id_use2;
  logic [REG_ADDR_W-1:0] id_dst;
  logic                  id_wr;
  logic                  id_load;
  logic                  flush;
  logic                  stall;
  logic                  ex_valid;
  logic [1:0]            fwd_sel1;
  logic [1:0]            fwd_sel2;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      fwd_cnt;
`endif

  int errors = 0;
  int checks = 0;

  alu_hazard_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .id_valid  (id_valid),
    .id_src1   (id_src1),
    .id_src2   (id_src2),
    .id_use1   (id_use1),
    .id_use2   (id_use2),
    .id_dst    (id_dst),
    .id_wr     (id_wr),
    .id_load   (id_load),
    .flush     (flush),
    .stall     (stall),
    .ex_valid  (ex_valid),
    .fwd_sel1  (fwd_sel1),
    .fwd_sel2  (fwd_sel2)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .fwd_cnt   (fwd_cnt)
`endif
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one decode slot.
  task automatic applyStimulus(input logic v, input int s1, input int s2,
                               input logic u1, input logic u2, input int d,
                               input logic wr, input logic ld, input logic fl);
    id_valid = v;
    id_src1  = REG_ADDR_W'(s1);
    id_src2  = REG_ADDR_W'(s2);
    id_use1  = u1;
    id_use2  = u2;
    id_dst   = REG_ADDR_W'(d);
    id_wr    = wr;
    id_load  = ld;
    flush    = fl;
  endtask

  // Compare all four control outputs against hand-computed values.
  task automatic checkOutput(input string tag, input logic exp_stall,
                             input logic exp_exv, input logic [1:0] exp_s1,
                             input logic [1:0] exp_s2);
    checks++;
    assert (stall === exp_stall) else begin
      errors++;
      $error("[TB] FAIL %s.stall: got %0b want %0b", tag, stall, exp_stall);
    end
    checks++;
    assert (ex_valid === exp_exv) else begin
      errors++;
      $error("[TB] FAIL %s.ex_valid: got %0b want %0b", tag, ex_valid, exp_exv);
    end
    checks++;
    assert (fwd_sel1 === exp_s1) else begin
      errors++;
      $error("[TB] FAIL %s.fwd_sel1: got %0d want %0d", tag, fwd_sel1, exp_s1);
    end
    checks++;
    assert (fwd_sel2 === exp_s2) else begin
      errors++;
      $error("[TB] FAIL %s.fwd_sel2: got %0d want %0d", tag, fwd_sel2, exp_s2);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Stimulus fields: valid, src1, src2, use1, use2, dst, wr, load, flush.
  // Expected values in checkOutput: stall for the slot just driven, then
  // ex_valid / fwd_sel1 / fwd_sel2 of the instruction issued on the last edge.
  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("reset", 0, 0, 2'd0, 2'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;

    // ADD r1 = r2 + r3, then SUB r2 = r1 - r3: EX/MEM forward on operand 1.
    applyStimulus(1, 2, 3, 1, 1, 1, 1, 0, 0);
    #1 checkOutput("add_r1", 0, 0, 2'd0, 2'd0);
    nextCycle();
    applyStimulus(1, 1, 3, 1, 1, 2, 1, 0, 0);
    #1 checkOutput("sub_id", 0, 1, 2'd0, 2'd0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("sub_ex", 0, 1, 2'd1, 2'd0);
    nextCycle();

    // ADD r1, NOP, AND r4 = r1 & r1: MEM/WB forward on both operands.
    applyStimulus(1, 5, 6, 1, 1, 1, 1, 0, 0);
    #1 checkOutput("add2_id", 0, 0, 2'd0, 2'd0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("nop_gap", 0, 1, 2'd0, 2'd0);
    nextCycle();
    applyStimulus(1, 1, 1, 1, 1, 4, 1, 0, 0);
    #1 checkOutput("and_id", 0, 0, 2'd0, 2'd0);
    nextCycle();

    // LOAD r5 then ADD r6 = r5 + r2: one stall, bubble, then select 2.
    applyStimulus(1, 7, 0, 1, 0, 5, 1, 1, 0);
    #1 checkOutput("and_ex", 0, 1, 2'd2, 2'd2);
    nextCycle();
    applyStimulus(1, 5, 2, 1, 1, 6, 1, 0, 0);
    #1 checkOutput("lu_stall", 1, 1, 2'd0, 2'd0);
    nextCycle();
    #1 checkOutput("lu_bubble", 0, 0, 2'd0, 2'd0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("lu_issue", 0, 1, 2'd2, 2'd0);
    nextCycle();

    // MOV r1, ADD r1, OR r7 = r1 | imm (src2 names r1 but is unused).
    applyStimulus(1, 3, 0, 1, 0, 1, 1, 0, 0);
    #1 checkOutput("mov_id", 0, 0, 2'd0, 2'd0);
    nextCycle();
    applyStimulus(1, 2, 2, 1, 1, 1, 1, 0, 0);
    #1 checkOutput("add3_id", 0, 1, 2'd0, 2'd0);
    nextCycle();
    applyStimulus(1, 1, 1, 1, 0, 7, 1, 0, 0);
    #1 checkOutput("or_id", 0, 1, 2'd0, 2'd0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("youngest", 0, 1, 2'd1, 2'd0);
    nextCycle();

    // LOAD r3, then a consumer naming r3 with both use bits clear: no stall.
    applyStimulus(1, 0, 0, 1, 0, 3, 1, 1, 0);
    #1 checkOutput("ld3_id", 0, 0, 2'd0, 2'd0);
    nextCycle();
    applyStimulus(1, 3, 3, 0, 0, 2, 1, 0, 0);
    #1 checkOutput("unused_id", 0, 1, 2'd0, 2'd0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("unused_ex", 0, 1, 2'd0, 2'd0);
    nextCycle();

    // LOAD r3 in EX, r3 consumer in ID with flush: flush beats stall.
    applyStimulus(1, 4, 0, 1, 0, 3, 1, 1, 0);
    #1 checkOutput("ld3b_id", 0, 0, 2'd0, 2'd0);
    nextCycle();
    applyStimulus(1, 3, 3, 1, 1, 0, 1, 0, 1);
    #1 checkOutput("flush_id", 0, 1, 2'd0, 2'd0);
    nextCycle();
    // ADD r0 = r3 + r0 re-issued with the load now in MEM.
    applyStimulus(1, 3, 0, 1, 1, 0, 1, 0, 0);
    #1 checkOutput("flush_ex", 0, 0, 2'd0, 2'd0);
    nextCycle();
    // SUB r1 = r0 - r0: register 0 forwards like any other.
    applyStimulus(1, 0, 0, 1, 1, 1, 1, 0, 0);
    #1 checkOutput("r0_id", 0, 1, 2'd2, 2'd0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("r0_ex", 0, 1, 2'd1, 2'd1);

`ifdef HAZARD_PERF_CNT_EN
    // One stall cycle; forwarded issues: SUB, AND, ADD r6, OR, ADD r0, SUB r1.
    checks++;
    assert (stall_cnt === CNT_W'(1)) else begin
      errors++;
      $error("[TB] FAIL stall_cnt: got %0d want 1", stall_cnt);
    end
    checks++;
    assert (fwd_cnt === CNT_W'(6)) else begin
      errors++;
      $error("[TB] FAIL fwd_cnt: got %0d want 6", fwd_cnt);
    end
`endif

    // Asynchronous reset mid-cycle while EX is valid with selects 1/1.
    #2;
    rst_n = 1'b0;
    #1 checkOutput("async_rst", 0, 0, 2'd0, 2'd0);
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    assert (stall_cnt === '0 && fwd_cnt === '0) else begin
      errors++;
      $error("[TB] FAIL cnt_rst: got %0d/%0d want 0/0", stall_cnt, fwd_cnt);
    end
`endif
    nextCycle();
    rst_n = 1'b1;

    // First issue after reset: ADD r1 = r1 + r1 sees no producers.
    applyStimulus(1, 1, 1, 1, 1, 1, 1, 0, 0);
    #1 checkOutput("post_rst_id", 0, 0, 2'd0, 2'd0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("post_rst_ex", 0, 1, 2'd0, 2'd0);
    nextCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
